// File: rtl/obc_dft_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : obc_dft_seq_ctrl
//  Purpose  : Bit-serial offset-binary-coded DFT bin sequencer. Loads 16
//             samples, streams one bit-slice per cycle to an external ROM
//             bank, accumulates the returned partial sums LSB first and
//             presents the bin value with a valid/ready handshake.
//  Options  : OBC_OFFSET_ADD_EN - when defined, one OFFSET cycle adds
//             rom_offset to the accumulator before the result is presented.
//  Revision : 1.0  initial release
// ============================================================================
module obc_dft_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [15:0]       x_bits,
    input  logic [ACC_W-1:0]  rom_sum,
    input  logic [ACC_W-1:0]  rom_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OFFSET  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] smp_q [16];

    logic              w_load_fire;
    logic [ACC_W-1:0]  w_acc_shift;

    assign w_load_fire = in_valid && in_ready_q;
    // Arithmetic halving keeps the accumulator's sign as weights shrink
    assign w_acc_shift = $unsigned($signed(acc_q) >>> 1);

`ifndef OBC_OFFSET_ADD_EN
    // Offset constant has no consumer when the OFFSET state is compiled out
    logic w_unused_offset;
    assign w_unused_offset = ^rom_offset;
`endif

    // Next-state and datapath update for the load / compute / offset / done sequence
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        case (state_q)
            S_LOAD: begin
                if (w_load_fire) begin
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d   = S_COMPUTE;
                        acc_d     = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                if (bit_cnt_q == C_LAST_BIT) begin
                    // Sign-bit slice carries negative weight
                    acc_d     = w_acc_shift - rom_sum;
                    bit_cnt_d = '0;
`ifdef OBC_OFFSET_ADD_EN
                    state_d   = S_OFFSET;
`else
                    state_d   = S_DONE;
`endif
                end else begin
                    acc_d     = w_acc_shift + rom_sum;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef OBC_OFFSET_ADD_EN
            S_OFFSET: begin
                acc_d   = acc_q + rom_offset;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_LOAD;
                    load_cnt_d = 4'd0;
                end
            end
            default: state_d = S_LOAD;
        endcase
        in_ready_d = (state_d == S_LOAD);
    end

    // State, counters, accumulator and sample store; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            load_cnt_q <= 4'd0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                smp_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            if (w_load_fire) begin
                smp_q[load_cnt_q] <= in_data;
            end
        end
    end

    // Bit-slice of all samples for the current bit position, zero outside COMPUTE
    always_comb begin
        x_bits = '0;
        if (state_q == S_COMPUTE) begin
            for (int k = 0; k < 16; k++) begin
                x_bits[k] = smp_q[k][bit_cnt_q];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_DONE);
    assign result    = out_valid ? acc_q : '0;
    assign busy      = !((state_q == S_LOAD) && (load_cnt_q == 4'd0));

endmodule
`default_nettype wire

// File: tb/tb_obc_dft_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obc_dft_seq_ctrl
//  Purpose  : Directed self-checking bench for obc_dft_seq_ctrl. A bench ROM
//             answers x_bits either with a constant or a weighted sum; a
//             frame-level model predicts slices and the bin value, and a
//             negedge compare process checks every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_obc_dft_seq_ctrl;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [15:0]   x_bits;
    logic [AW-1:0] rom_sum;
    logic [AW-1:0] rom_offset;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] result;
    logic          busy;

    obc_dft_seq_ctrl #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .x_bits     (x_bits),
        .rom_sum    (rom_sum),
        .rom_offset (rom_offset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bench ROM: weight per sample position, summed over set slice bits
    logic          rom_mode;
    logic [AW-1:0] rom_const;

    function automatic logic [AW-1:0] rom_w(input int k);
        return (32'(k) * 32'h0101_0003) + 32'h0000_0777;
    endfunction

    function automatic logic [AW-1:0] rom_of(input logic [15:0] xb);
        logic [AW-1:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) if (xb[k]) s = s + rom_w(k);
        return s;
    endfunction

    assign rom_sum = rom_mode ? rom_of(x_bits) : rom_const;

    // Frame model
    logic [DW-1:0] smp    [16];
    logic [15:0]   exp_xb [16];
    logic [AW-1:0] exp_res;

    task automatic compute_model();
        logic signed [AW-1:0] a;
        logic [AW-1:0]        r;
        logic [15:0]          xb;
        a = '0;
        for (int b = 0; b < DW; b++) begin
            for (int k = 0; k < 16; k++) xb[k] = smp[k][b];
            exp_xb[b] = xb;
            r = rom_mode ? rom_of(xb) : rom_const;
            if (b < DW - 1) a = (a >>> 1) + $signed(r);
            else            a = (a >>> 1) - $signed(r);
        end
`ifdef OBC_OFFSET_ADD_EN
        a = a + $signed(rom_offset);
`endif
        exp_res = a;
    endtask

    // Scoreboard counters and comparison
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle expectations
    logic          chk_on = 1'b0;
    logic          e_ir, e_ov, e_bz;
    logic [15:0]   e_xb;
    logic [AW-1:0] e_res;

    task automatic set_exp(input logic ir, input logic ov, input logic bz,
                           input logic [15:0] xb, input logic [AW-1:0] res);
        e_ir = ir; e_ov = ov; e_bz = bz; e_xb = xb; e_res = res;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready",  32'(in_ready),  32'(e_ir));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("busy",      32'(busy),      32'(e_bz));
            chk("x_bits",    32'(x_bits),    32'(e_xb));
            if (e_ov) chk("result", result, e_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"},    result,         32'd0);
        chk({tag, "_x_bits"},    32'(x_bits),    32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // One frame: load (optional idle gap), compute, optional offset, done hold + handshake
    task automatic run_frame(input int hold, input int abort_at, input int gap_at);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                step();
                in_valid = 1'b0; out_ready = 1'b0;
                set_exp(1'b1, 1'b0, i != 0, 16'h0, '0);
            end
            step();
            in_valid = 1'b1; in_data = smp[i]; out_ready = 1'b0;
            set_exp(1'b1, 1'b0, i != 0, 16'h0, '0);
        end
        for (int b = 0; b < DW; b++) begin
            step();
            in_valid = 1'b1; in_data = 16'hA5A5 ^ 16'(b);
            set_exp(1'b0, 1'b0, 1'b1, exp_xb[b], '0);
            if (b == abort_at) begin
                @(negedge clk);
                #1;
                rst_n = 1'b0;
                set_exp(1'b0, 1'b0, 1'b0, 16'h0, '0);
                #1;
                chk_all_zero("abort_rst");
                in_valid = 1'b0;
                step();
                rst_n = 1'b1;
                set_exp(1'b0, 1'b0, 1'b0, 16'h0, '0);
                return;
            end
        end
`ifdef OBC_OFFSET_ADD_EN
        step();
        set_exp(1'b0, 1'b0, 1'b1, 16'h0, '0);
`endif
        for (int h = 0; h < hold; h++) begin
            step();
            out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7E57;
            set_exp(1'b0, 1'b1, 1'b1, 16'h0, exp_res);
        end
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h3C3C;
        set_exp(1'b0, 1'b1, 1'b1, 16'h0, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rom_mode = 1'b0; rom_const = '0; rom_offset = 32'h0000_0010;
        set_exp(1'b0, 1'b0, 1'b0, 16'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        chk_on = 1'b1;

        // All-zero samples, zero ROM
        for (int k = 0; k < 16; k++) smp[k] = '0;
        rom_mode = 1'b0; rom_const = '0;
        compute_model();
`ifdef OBC_OFFSET_ADD_EN
        chk("model_zero", exp_res, 32'h0000_0010);
`else
        chk("model_zero", exp_res, 32'h0000_0000);
`endif
        run_frame(0, -1, -1);

        // Constant ROM 0x100: accumulator settles at 511, final 255-256
        for (int k = 0; k < 16; k++) smp[k] = 16'(k * 16'h1111);
        rom_mode = 1'b0; rom_const = 32'h0000_0100;
        compute_model();
`ifdef OBC_OFFSET_ADD_EN
        chk("model_const", exp_res, 32'h0000_000F);
`else
        chk("model_const", exp_res, 32'hFFFF_FFFF);
`endif
        run_frame(2, -1, -1);

        // Single bits at x0 LSB and x15 MSB; long DONE hold with in_valid high
        for (int k = 0; k < 16; k++) smp[k] = '0;
        smp[0] = 16'h0001; smp[15] = 16'h8000;
        rom_mode = 1'b1;
        compute_model();
        chk("model_xb0",  32'(exp_xb[0]),  32'h0000_0001);
        chk("model_xb5",  32'(exp_xb[5]),  32'h0000_0000);
        chk("model_xb15", 32'(exp_xb[15]), 32'h0000_8000);
        run_frame(10, -1, -1);

        // Random frame aborted by reset at bit 7, then rerun in full
        for (int k = 0; k < 16; k++) smp[k] = 16'($urandom);
        rom_mode = 1'b1;
        compute_model();
        run_frame(0, 7, -1);
        run_frame(1, -1, 5);

        // Negative samples, immediate handshake
        for (int k = 0; k < 16; k++) smp[k] = 16'h8000 | 16'(k * 3);
        compute_model();
        run_frame(0, -1, -1);

        // Back in LOAD idle after the final handshake
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 16'h0, '0);
        step();
        set_exp(1'b1, 1'b0, 1'b0, 16'h0, '0);
        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obc_dft_seq_ctrl.md
OBC_DFT_SEQ_CTRL -- requirements
Module: obc_dft_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: bit width of each input sample; number of COMPUTE cycles.
REQ-002 Parameter ACC_W, default 32: accumulator, rom_sum and result width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  sample offered on in_data.
REQ-006 in_data  input  DATA_W  two's-complement sample; samples arrive in order x0..x15.
REQ-007 in_ready  output  1  high only in LOAD; a sample transfers when in_valid&&in_ready.
REQ-008 x_bits  output  16  bit-slice to ROM bank; x_bits[k] = bit b of sample k during COMPUTE cycle b, else 0.
REQ-009 rom_sum  input  ACC_W  combinational sum of the 8 ROM partial outputs for the current x_bits, same cycle.
REQ-010 rom_offset  input  ACC_W  OBC offset constant, sampled only in OFFSET state.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result when out_valid&&out_ready.
REQ-013 result  output  ACC_W  accumulated DFT bin value, stable while out_valid.
REQ-014 busy  output  1  high in every state except LOAD with load count 0.

Function
REQ-015 States: LOAD, COMPUTE, OFFSET, DONE; reset state LOAD.
REQ-016 LOAD: each transfer writes in_data into sample register [load_cnt] and increments 4-bit load_cnt; transfer at load_cnt=15 goes to COMPUTE, clears acc and bit_cnt.
REQ-017 COMPUTE lasts exactly DATA_W cycles, bit_cnt 0..DATA_W-1, LSB first.
REQ-018 For bit_cnt < DATA_W-1: acc <= (acc >>> 1) + rom_sum (arithmetic shift, ACC_W wrap, no saturation).
REQ-019 For bit_cnt = DATA_W-1 (sign bit): acc <= (acc >>> 1) - rom_sum; then go to OFFSET (macro defined) or DONE (macro undefined).
REQ-020 OFFSET (one cycle): acc <= acc + rom_offset, then DONE.
REQ-021 DONE: out_valid=1, result=acc; on out_ready go to LOAD with load_cnt=0 next cycle; out_ready low holds DONE and result indefinitely.
REQ-022 in_ready=0 in COMPUTE, OFFSET, DONE; in_valid there is ignored and no sample is consumed.
REQ-023 Latency: first out_valid cycle is DATA_W+1 cycles (macro defined) or DATA_W cycles (undefined) after the clock edge accepting sample 15.
REQ-024 Back-to-back: in_ready rises the cycle after the DONE handshake; no sample transfers in the handshake cycle.

Reset
REQ-025 rst_n low asynchronously forces LOAD, load_cnt=0, bit_cnt=0, acc=0, sample registers=0.
REQ-026 During reset: in_ready=0, out_valid=0, result=0, x_bits=0, busy=0; in_ready=1 from the first edge after release.
REQ-027 Reset mid-COMPUTE or mid-DONE discards the partial frame; no result is emitted for it.

Configuration
REQ-028 Macro OBC_OFFSET_ADD_EN: defined -> OFFSET state present, rom_offset added once per frame; undefined -> OFFSET state absent, rom_offset ignored, COMPUTE goes directly to DONE.

Verification
REQ-029 Load 16 zero samples, rom_sum=0 -> after DATA_W cycles (no macro), out_valid=1, result=32'h0000_0000.
REQ-030 DATA_W=16, rom_sum held at 32'h0000_0100, no macro -> result=32'hFFFF_FFFF (acc settles at 511, final 255-256).
REQ-031 Same as REQ-030 with OBC_OFFSET_ADD_EN, rom_offset=32'h0000_0010 -> result=32'h0000_000F, latency one cycle longer.
REQ-032 Samples x0=16'h0001, x15=16'h8000, others 0 -> x_bits=16'h0001 at bit_cnt 0, 16'h8000 at bit_cnt 15, 16'h0000 otherwise.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> result stable, in_ready=0, no sample consumed; out_ready=1 -> in_ready=1 next cycle.
REQ-034 Pulse rst_n low at bit_cnt=7 -> outputs zero immediately, in_ready=1 after release, next full frame produces correct result.
